// File: rtl/axi4_lite_gpio_slave.sv
// -----------------------------------------------------------------------------
// axi4_lite_gpio_slave
// AXI4-Lite register slave driving an 8-bit LED bank, an 8-bit seven-segment
// latch and a compare-match timer with a maskable, registered interrupt.
//
// Ports
//   ACLK, ARESETn            clock, async active-low reset (release synchronised)
//   S_AW*/S_W*/S_B*          AXI4-Lite write address / data / response
//   S_AR*/S_R*               AXI4-Lite read address / data
//   LED_OUT, SEVENSEG_OUT    register outputs
//   IRQ_OUT                  registered TMR_HIT & IRQ_EN
//
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for address and/or data
//   W_ADDR | address captured, waiting for data
//   W_DATA | data captured, waiting for address
//   W_RESP | response valid, waiting for S_BREADY
// Read FSM
//   state  | meaning
//   R_IDLE | waiting for read address
//   R_DATA | read data valid, waiting for S_RREADY
// -----------------------------------------------------------------------------
module axi4_lite_gpio_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   S_AWADDR,
  input  logic                    S_AWVALID,
  output logic                    S_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic                    S_WVALID,
  output logic                    S_WREADY,
  output logic                    S_BVALID,
  output logic [1:0]              S_BRESP,
  input  logic                    S_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_ARADDR,
  input  logic                    S_ARVALID,
  output logic                    S_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_RDATA,
  output logic [1:0]              S_RRESP,
  output logic                    S_RVALID,
  input  logic                    S_RREADY,
  output logic [7:0]              LED_OUT,
  output logic [7:0]              SEVENSEG_OUT,
  output logic                    IRQ_OUT
);

  localparam int         NB          = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                  rst_done_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         wstrb_q;
  logic [1:0]            bresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic [7:0]            led_q, seg_q;
  logic [1:0]            ctrl_q;
  logic                  hit_q, hit_d;
  logic [DATA_WIDTH-1:0] cmp_q, cmp_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic                  irq_q;

  logic                  aw_hs, w_hs, ar_hs;
  logic                  wr_fire;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_strb;
  logic [2:0]            wr_idx, rd_idx;
  logic                  wr_ok, wr_en, rd_ok;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  cmp_wr, hit_clr, tmr_match;
  logic                  unused_addr_lsbs;

  // Ready outputs stay low until one clock after reset release.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) rst_done_q <= 1'b0;
    else          rst_done_q <= 1'b1;
  end

  assign S_AWREADY = rst_done_q && (w_state_q == W_IDLE || w_state_q == W_DATA);
  assign S_WREADY  = rst_done_q && (w_state_q == W_IDLE || w_state_q == W_ADDR);
  assign S_ARREADY = rst_done_q && (r_state_q == R_IDLE);
  assign S_BVALID  = (w_state_q == W_RESP);
  assign S_RVALID  = (r_state_q == R_DATA);
  assign S_BRESP   = bresp_q;
  assign S_RDATA   = rdata_q;
  assign S_RRESP   = rresp_q;

  assign aw_hs = S_AWVALID && S_AWREADY;
  assign w_hs  = S_WVALID && S_WREADY;
  assign ar_hs = S_ARVALID && S_ARREADY;

  // Address/data for the completing write come from the bus when they arrive
  // on the completing edge, otherwise from the holding registers.
  always_comb begin
    w_state_d = w_state_q;
    wr_fire   = 1'b0;
    wr_addr   = aw_addr_q;
    wr_data   = wdata_q;
    wr_strb   = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_state_d = W_RESP;
          wr_fire   = 1'b1;
          wr_addr   = S_AWADDR;
          wr_data   = S_WDATA;
          wr_strb   = S_WSTRB;
        end else if (aw_hs) begin
          w_state_d = W_ADDR;
        end else if (w_hs) begin
          w_state_d = W_DATA;
        end
      end
      W_ADDR: begin
        if (w_hs) begin
          w_state_d = W_RESP;
          wr_fire   = 1'b1;
          wr_data   = S_WDATA;
          wr_strb   = S_WSTRB;
        end
      end
      W_DATA: begin
        if (aw_hs) begin
          w_state_d = W_RESP;
          wr_fire   = 1'b1;
          wr_addr   = S_AWADDR;
        end
      end
      W_RESP:  if (S_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (S_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  // Writable registers are offsets 0x00..0x10; TMR_CNT and above are rejected.
  assign wr_idx  = wr_addr[4:2];
  assign wr_ok   = (wr_addr[ADDR_WIDTH-1:5] == '0) && (wr_idx < 3'd5);
  assign wr_en   = wr_fire && wr_ok;
  assign rd_idx  = S_ARADDR[4:2];
  assign rd_ok   = (S_ARADDR[ADDR_WIDTH-1:5] == '0) && (rd_idx < 3'd6);
  assign unused_addr_lsbs = ^{wr_addr[1:0], S_ARADDR[1:0]};

  assign cmp_wr    = wr_en && (wr_idx == 3'd4);
  assign hit_clr   = wr_en && (wr_idx == 3'd3) && wr_strb[0] && wr_data[0];
  assign tmr_match = ctrl_q[1] && (cmp_q != '0) && (cnt_q == cmp_q);

  always_comb begin
    cmp_d = cmp_q;
    if (cmp_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_strb[i]) cmp_d[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  // A CMP write restarts the count; a timer hit beats a same-edge W1C clear.
  always_comb begin
    cnt_d = cnt_q;
    if (cmp_wr)         cnt_d = '0;
    else if (tmr_match) cnt_d = '0;
    else if (ctrl_q[1]) cnt_d = cnt_q + DATA_WIDTH'(1);
    hit_d = hit_q;
    if (tmr_match)    hit_d = 1'b1;
    else if (hit_clr) hit_d = 1'b0;
  end

  always_comb begin
    rd_data = '0;
    if (rd_ok) begin
      case (rd_idx)
        3'd0:    rd_data[7:0] = led_q;
        3'd1:    rd_data[7:0] = seg_q;
        3'd2:    rd_data[1:0] = ctrl_q;
        3'd3:    rd_data[0]   = hit_q;
        3'd4:    rd_data      = cmp_q;
        3'd5:    rd_data      = cnt_q;
        default: rd_data      = '0;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      led_q     <= '0;
      seg_q     <= '0;
      ctrl_q    <= '0;
      hit_q     <= 1'b0;
      cmp_q     <= '0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (aw_hs) aw_addr_q <= S_AWADDR;
      if (w_hs) begin
        wdata_q <= S_WDATA;
        wstrb_q <= S_WSTRB;
      end
      if (wr_fire) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if (wr_en && wr_strb[0]) begin
        case (wr_idx)
          3'd0:    led_q  <= wr_data[7:0];
          3'd1:    seg_q  <= wr_data[7:0];
          3'd2:    ctrl_q <= wr_data[1:0];
          default: ;
        endcase
      end
      cmp_q <= cmp_d;
      cnt_q <= cnt_d;
      hit_q <= hit_d;
      irq_q <= hit_q && ctrl_q[0];
    end
  end

  assign LED_OUT      = led_q;
  assign SEVENSEG_OUT = seg_q;
  assign IRQ_OUT      = irq_q;

endmodule
